// File: rtl/eight_bit_divider_if.sv
// Operand/result handshake bundle between a controller and eight_bit_divider.
interface eight_bit_divider_if;
  localparam int unsigned W = 8;

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/eight_bit_divider.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVZERO_FLAG_EN: divisor 0 short-circuits to a 1-cycle result with div_zero set.
module eight_bit_divider (
  input  logic                 clk,
  input  logic                 reset,
  eight_bit_divider_if.slave   bus
);
  localparam int unsigned W     = 8;
  localparam int unsigned RW    = W + 1;
  localparam int unsigned CW    = 4;
  localparam int unsigned ITERS = 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [RW-1:0] r, r_n;
  logic [W-1:0]  q, q_n;
  logic [W-1:0]  d, d_n;
  logic [CW-1:0] count, count_n;
  logic          busy, busy_n;
  logic          done, done_n;
  logic [W-1:0]  quotient, quotient_n;
  logic [W-1:0]  remainder, remainder_n;
  logic          div_zero, div_zero_n;
  logic [RW-1:0] s, t;

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      q         <= q_n;
      d         <= d_n;
      count     <= count_n;
      busy      <= busy_n;
      done      <= done_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      div_zero  <= div_zero_n;
    end
  end

  // Next-state, shift-and-subtract iteration and result capture.
  always_comb begin
    state_n     = state;
    r_n         = r;
    q_n         = q;
    d_n         = d;
    count_n     = count;
    busy_n      = busy;
    done_n      = 1'b0;
    quotient_n  = quotient;
    remainder_n = remainder;
    div_zero_n  = div_zero;
    s           = {r[W-1:0], q[W-1]};
    t           = s - {1'b0, d};

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          r_n         = '0;
          q_n         = bus.dividend;
          d_n         = bus.divisor;
          count_n     = '0;
          quotient_n  = '0;
          remainder_n = '0;
          div_zero_n  = 1'b0;
          busy_n      = 1'b1;
          state_n     = RUN;
`ifdef DIVZERO_FLAG_EN
          if (bus.divisor == '0) begin
            quotient_n  = '1;
            remainder_n = bus.dividend;
            div_zero_n  = 1'b1;
            done_n      = 1'b1;
            busy_n      = 1'b0;
            state_n     = IDLE;
          end
`endif
        end
      end
      RUN: begin
        // A borrow out of the 9-bit subtract means the divisor did not fit: restore.
        if (!t[RW-1]) begin
          r_n = t;
          q_n = {q[W-2:0], 1'b1};
        end else begin
          r_n = s;
          q_n = {q[W-2:0], 1'b0};
        end
        count_n = count + CW'(1);
        if (count == CW'(ITERS - 1)) begin
          quotient_n  = q_n;
          remainder_n = r_n[W-1:0];
          done_n      = 1'b1;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.div_zero  = div_zero;
endmodule

// File: tb/tb_eight_bit_divider.sv
// Self-checking bench for eight_bit_divider: vector table, directed corner sequences, random vs. arithmetic model.
module tb_eight_bit_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  eight_bit_divider_if bus();

  eight_bit_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit flag_build();
`ifdef DIVZERO_FLAG_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Edges from accept until done is visible (0 means done right after the accept edge).
  function automatic int exp_latency(input logic [7:0] b);
    return (b == 8'd0 && flag_build()) ? 0 : 8;
  endfunction

  // Full transaction from an idle negedge: checks latency, busy span, results, single-cycle done.
  task automatic do_div(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er);
    int n;
    int nb;
    int lat;
    lat = exp_latency(b);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    nb = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) nb++;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, lat);
    check({name, " busy_cycles"}, nb, lat);
    check({name, " busy_at_done"}, int'(bus.busy), 0);
    check({name, " quotient"}, int'(bus.quotient), int'(eq));
    check({name, " remainder"}, int'(bus.remainder), int'(er));
    check({name, " div_zero"}, int'(bus.div_zero), int'(b == 8'd0 && flag_build()));
    @(negedge clk);
    check({name, " done_width"}, int'(bus.done), 0);
    check({name, " q_hold"}, int'(bus.quotient), int'(eq));
  endtask

  initial begin
    vec_t vecs[$];
    int t1, t2, n;
    bit  saw_done;
    logic [7:0] a, b;

    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 8'd0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check("rst quotient", int'(bus.quotient), 0);
    check("rst remainder", int'(bus.remainder), 0);
    check("rst div_zero", int'(bus.div_zero), 0);
    reset = 1'b0;
    @(negedge clk);

    vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5});
    vecs.push_back('{8'd100, 8'd3,   8'd33,  8'd1});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254});
    vecs.push_back('{8'd128, 8'd2,   8'd64,  8'd0});
    vecs.push_back('{8'd17,  8'd16,  8'd1,   8'd1});
    vecs.push_back('{8'd255, 8'd16,  8'd15,  8'd15});
    vecs.push_back('{8'd165, 8'd0,   8'd255, 8'd165});
    vecs.push_back('{8'd0,   8'd0,   8'd255, 8'd0});
    foreach (vecs[i]) do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

    // Back-to-back: 255/1 then 5/9 with start held through the done cycle.
    bus.start = 1'b1;
    bus.dividend = 8'd255;
    bus.divisor = 8'd1;
    @(negedge clk);
    t1 = cyc;
    n = 0;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    check("b2b first quotient", int'(bus.quotient), 255);
    check("b2b first remainder", int'(bus.remainder), 0);
    bus.dividend = 8'd5;
    bus.divisor = 8'd9;
    @(negedge clk);
    t2 = cyc;
    bus.start = 1'b0;
    check("b2b accept gap", t2 - t1, 9);
    check("b2b busy", int'(bus.busy), 1);
    check("b2b clear quotient", int'(bus.quotient), 0);
    n = 0;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    check("b2b second latency", n, 8);
    check("b2b second quotient", int'(bus.quotient), 0);
    check("b2b second remainder", int'(bus.remainder), 5);
    @(negedge clk);

    // Start while busy is ignored.
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 8'd7;
    bus.divisor = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    n = 4;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    check("ignore latency", n, 8);
    check("ignore quotient", int'(bus.quotient), 33);
    check("ignore remainder", int'(bus.remainder), 1);
    @(negedge clk);

    // Reset mid-division aborts without done.
    bus.start = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort quotient", int'(bus.quotient), 0);
    check("abort remainder", int'(bus.remainder), 0);
    check("abort div_zero", int'(bus.div_zero), 0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort no_done", int'(saw_done), 0);
    do_div("after_abort", 8'd50, 8'd5, 8'd10, 8'd0);

    // Random operands against plain arithmetic.
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) do_div($sformatf("rnd%0d", i), a, b, 8'hFF, a);
      else           do_div($sformatf("rnd%0d", i), a, b, 8'(a / b), 8'(a % b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
